// File: rtl/crc_chk_pkg.sv
// Shared types and defaults for the CRC check sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package crc_chk_pkg;

  // Sequencer FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Default widths, shared with the CRC calculator
  localparam int DEF_CRC_GPW_MAX = 8;
  localparam int DEF_DWIDTH      = 16;

endpackage

// File: rtl/crc_check_sequencer_if.sv
// Request, calculator and result signals of the CRC check sequencer.
// Latency: n/a (wiring only).
// Backpressure: startReady gates requests; resValid is held until resAck.
`timescale 1ns/1ps
interface crc_check_sequencer_if
  import crc_chk_pkg::*;
#(
  parameter int CRC_GPW_MAX = DEF_CRC_GPW_MAX,
  parameter int DWIDTH      = DEF_DWIDTH,
  parameter int CNT_W       = 16
);
  // request side
  logic                   startIn;
  logic                   startReady;
  logic [DWIDTH-1:0]      dataIn;
  logic [CRC_GPW_MAX-1:0] genPolyIn;
  logic [CRC_GPW_MAX-1:0] expCrcIn;
  // calculator side
  logic                   calcEn;
  logic [DWIDTH-1:0]      calcData;
  logic [CRC_GPW_MAX-1:0] calcPoly;
  logic [CRC_GPW_MAX-1:0] calcCrc;
  logic                   calcReady;
  // result side
  logic                   resValid;
  logic                   resPass;
  logic                   resTimeout;
  logic [CRC_GPW_MAX-1:0] resCrc;
  logic                   resAck;
  logic [CNT_W-1:0]       passCnt;
  logic [CNT_W-1:0]       failCnt;

  // Sequencer view
  modport slave (
    input  startIn, dataIn, genPolyIn, expCrcIn, calcCrc, calcReady, resAck,
    output startReady, calcEn, calcData, calcPoly,
           resValid, resPass, resTimeout, resCrc, passCnt, failCnt
  );

  // Environment view (requester, calculator and result consumer)
  modport master (
    output startIn, dataIn, genPolyIn, expCrcIn, calcCrc, calcReady, resAck,
    input  startReady, calcEn, calcData, calcPoly,
           resValid, resPass, resTimeout, resCrc, passCnt, failCnt
  );
endinterface

// File: rtl/crc_chk_sat_cnt.sv
// Saturating event counter; sticks at all-ones.
// Latency: count visible the cycle after inc_en.
// Backpressure: none; increments beyond all-ones are dropped.
`timescale 1ns/1ps
module crc_chk_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: +1 unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc_en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/crc_check_sequencer.sv
// Feeds one frame to the CRC calculator and checks the returned CRC against the expected one.
// Latency: calcEn the cycle after accept; result the cycle after calcReady (or TIMEOUT_CYC+1 after calcEn).
// Backpressure: one frame in flight; result held until resAck, new start only back in IDLE.
// Build option: define CRC_CHK_STATS_EN to include the pass/fail statistics counters.
`timescale 1ns/1ps
module crc_check_sequencer
  import crc_chk_pkg::*;
#(
  parameter int CRC_GPW_MAX = DEF_CRC_GPW_MAX,
  parameter int DWIDTH      = DEF_DWIDTH,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  crc_check_sequencer_if.slave bus
);
  // Wide enough to hold TIMEOUT_CYC; the counter leaves WAIT on reaching it, so it never wraps
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t                 state_q, state_d;
  logic [DWIDTH-1:0]      data_q, data_d;
  logic [CRC_GPW_MAX-1:0] poly_q, poly_d;
  logic [CRC_GPW_MAX-1:0] exp_q, exp_d;
  logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic                   res_pass_q, res_pass_d;
  logic                   res_tmo_q, res_tmo_d;
  logic [CRC_GPW_MAX-1:0] res_crc_q, res_crc_d;

  // Next-state and datapath capture for the frame sequencer
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    poly_d     = poly_q;
    exp_d      = exp_q;
    tmo_cnt_d  = tmo_cnt_q;
    res_pass_d = res_pass_q;
    res_tmo_d  = res_tmo_q;
    res_crc_d  = res_crc_q;
    case (state_q)
      IDLE: begin
        if (bus.startIn) begin
          data_d  = bus.dataIn;
          poly_d  = bus.genPolyIn;
          exp_d   = bus.expCrcIn;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        // calcReady seen here belongs to an earlier request and is ignored
        tmo_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (bus.calcReady) begin
          // an answer on the last allowed cycle still counts as an answer
          res_crc_d  = bus.calcCrc;
          res_pass_d = (bus.calcCrc == exp_q);
          res_tmo_d  = 1'b0;
          state_d    = REPORT;
        end else if (tmo_cnt_q == TMO_LAST) begin
          res_crc_d  = '0;
          res_pass_d = 1'b0;
          res_tmo_d  = 1'b1;
          state_d    = REPORT;
        end
      end
      REPORT: begin
        if (bus.resAck) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-frame registers; reset abandons any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      poly_q     <= '0;
      exp_q      <= '0;
      tmo_cnt_q  <= '0;
      res_pass_q <= 1'b0;
      res_tmo_q  <= 1'b0;
      res_crc_q  <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      poly_q     <= poly_d;
      exp_q      <= exp_d;
      tmo_cnt_q  <= tmo_cnt_d;
      res_pass_q <= res_pass_d;
      res_tmo_q  <= res_tmo_d;
      res_crc_q  <= res_crc_d;
    end
  end

  assign bus.startReady = (state_q == IDLE);
  assign bus.calcEn     = (state_q == LAUNCH);
  assign bus.calcData   = data_q;
  assign bus.calcPoly   = poly_q;
  assign bus.resValid   = (state_q == REPORT);
  assign bus.resPass    = res_pass_q;
  assign bus.resTimeout = res_tmo_q;
  assign bus.resCrc     = res_crc_q;

`ifdef CRC_CHK_STATS_EN
  logic             result_done;
  logic             pass_inc;
  logic             fail_inc;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  // Exactly one counter steps on every WAIT->REPORT transition
  assign result_done = (state_q == WAIT) && (state_d == REPORT);
  assign pass_inc    = result_done &&  res_pass_d;
  assign fail_inc    = result_done && !res_pass_d;

  crc_chk_sat_cnt #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_en (pass_inc),
    .cnt    (pass_cnt)
  );

  crc_chk_sat_cnt #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_en (fail_inc),
    .cnt    (fail_cnt)
  );

  assign bus.passCnt = pass_cnt;
  assign bus.failCnt = fail_cnt;
`else
  assign bus.passCnt = '0;
  assign bus.failCnt = '0;
`endif
endmodule
